// File: rtl/enemy_chaser_if.sv
// Bus between the VGA/game top level and one enemy_chaser instance.
// master: game side (drives frame strobe, requests, player and pixel coords).
// slave : enemy side (returns sprite hit/address, position, direction, status).
interface enemy_chaser_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              frame_clk;
  logic              spawn_req;
  logic              hit;
  logic [1:0]        damage;
  logic [8:0]        Player_X;
  logic [8:0]        Player_Y;
  logic [8:0]        PixelX;
  logic [8:0]        PixelY;
  logic              is_obj;
  logic [ADDR_W-1:0] Obj_address;
  logic [8:0]        Obj_X_Pos;
  logic [8:0]        Obj_Y_Pos;
  logic [1:0]        Obj_Direction;
  logic              alive;
  logic              kill;

  modport master (
    output frame_clk, spawn_req, hit, damage, Player_X, Player_Y, PixelX, PixelY,
    input  is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction, alive, kill
  );

  modport slave (
    input  frame_clk, spawn_req, hit, damage, Player_X, Player_Y, PixelX, PixelY,
    output is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction, alive, kill
  );
endinterface

// File: rtl/enemy_chaser.sv
// One boxhead enemy: chases the player, takes hits, stuns, dies, respawns,
// and produces the per-pixel sprite hit flag and sprite-ROM address.
// Ports:
//   Clk    - system clock
//   Reset  - synchronous, active-high
//   bus    - enemy_chaser_if.slave (frame strobe, spawn/hit inputs, player and
//            pixel coords in; is_obj/Obj_address (combinational), position,
//            direction, alive, kill out)
module enemy_chaser #(
  parameter int unsigned SPAWN_X        = 100,
  parameter int unsigned SPAWN_Y        = 60,
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned HEIGHT         = 26,
  parameter int unsigned X_MAX          = 319,
  parameter int unsigned Y_MAX          = 239,
  parameter int unsigned STEP           = 1,
  parameter int unsigned SPEED_DIV      = 4,
  parameter int unsigned DIAGONAL       = 0,
  parameter int unsigned MAX_HP         = 3,
  parameter int unsigned STUN_FRAMES    = 8,
  parameter int unsigned DEATH_FRAMES   = 30,
  parameter int unsigned SPAWN_ON_RESET = 1,
  parameter int unsigned ADDR_W         = 14
) (
  input logic         Clk,
  input logic         Reset,
  enemy_chaser_if.slave bus
);

  localparam int unsigned POS_W   = 9;
  localparam int unsigned DIV_W   = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int unsigned HP_W    = $clog2(MAX_HP + 4);
  localparam int unsigned TMR_MAX = (STUN_FRAMES > DEATH_FRAMES) ? STUN_FRAMES : DEATH_FRAMES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [POS_W-1:0] X_SPAWN = POS_W'(SPAWN_X - WIDTH / 2);
  localparam logic [POS_W-1:0] Y_SPAWN = POS_W'(SPAWN_Y - HEIGHT / 2);
  localparam logic [POS_W-1:0] X_BOUND = POS_W'(X_MAX - WIDTH);
  localparam logic [POS_W-1:0] Y_BOUND = POS_W'(Y_MAX - HEIGHT);
  localparam logic [POS_W:0]   STEP_V  = (POS_W + 1)'(STEP);
  localparam logic [HP_W-1:0]  HP_FULL = HP_W'(MAX_HP);

  typedef enum logic [1:0] {IDLE, CHASE, STUN, DYING} state_t;

  state_t             state;
  logic [POS_W-1:0]   pos_x, pos_y;
  logic [1:0]         dir, step_cnt;
  logic [HP_W-1:0]    hp;
  logic [DIV_W-1:0]   div_cnt;
  logic [TMR_W-1:0]   timer;
  logic               fc_meta, fc_sync, fc_prev, frame_edge;
  logic               kill_q;

  // One axis step toward target, limited to STEP, never past the target,
  // and never beyond the upper screen bound.
  function automatic logic [POS_W-1:0] approach(input logic [POS_W-1:0] pos,
                                                input logic [POS_W-1:0] target,
                                                input logic [POS_W-1:0] bound);
    logic [POS_W:0] gap, cand;
    cand = {1'b0, pos};
    if (pos < target) begin
      gap  = {1'b0, target} - {1'b0, pos};
      cand = {1'b0, pos} + ((gap < STEP_V) ? gap : STEP_V);
      if (cand > {1'b0, bound}) cand = {1'b0, bound};
    end else if (pos > target) begin
      gap  = {1'b0, pos} - {1'b0, target};
      cand = {1'b0, pos} - ((gap < STEP_V) ? gap : STEP_V);
    end
    return cand[POS_W-1:0];
  endfunction

  // Candidate move for this tick; Y waits for X alignment unless DIAGONAL.
  logic [POS_W-1:0] cand_x, cand_y;
  logic             x_moves, y_moves, moved;
  logic [1:0]       nxt_dir;

  always_comb begin
    cand_x  = approach(pos_x, bus.Player_X, X_BOUND);
    cand_y  = approach(pos_y, bus.Player_Y, Y_BOUND);
    x_moves = (cand_x != pos_x);
    y_moves = ((DIAGONAL != 0) || (pos_x == bus.Player_X)) && (cand_y != pos_y);
    moved   = x_moves | y_moves;
    nxt_dir = dir;
    if (x_moves)      nxt_dir = (cand_x > pos_x) ? 2'd3 : 2'd1;
    else if (y_moves) nxt_dir = (cand_y > pos_y) ? 2'd0 : 2'd2;
  end

  logic hit_valid, lethal, move_tick;

  always_comb begin
    hit_valid = bus.hit && (bus.damage != 2'd0);
    lethal    = (hp <= HP_W'(bus.damage));
    move_tick = frame_edge && (div_cnt == DIV_W'(SPEED_DIV - 1));
  end

  // State machine, movement, health, frame-strobe synchroniser.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= (SPAWN_ON_RESET != 0) ? CHASE : IDLE;
      pos_x      <= X_SPAWN;
      pos_y      <= Y_SPAWN;
      dir        <= 2'd0;
      step_cnt   <= 2'd0;
      hp         <= HP_FULL;
      div_cnt    <= '0;
      timer      <= '0;
      kill_q     <= 1'b0;
      fc_meta    <= 1'b0;
      fc_sync    <= 1'b0;
      fc_prev    <= 1'b0;
      frame_edge <= 1'b0;
    end else begin
      fc_meta    <= bus.frame_clk;
      fc_sync    <= fc_meta;
      fc_prev    <= fc_sync;
      frame_edge <= fc_sync & ~fc_prev;
      kill_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.spawn_req) begin
            pos_x   <= X_SPAWN;
            pos_y   <= Y_SPAWN;
            hp      <= HP_FULL;
            dir     <= 2'd0;
            div_cnt <= '0;
            state   <= CHASE;
          end
        end
        CHASE: begin
          // A hit takes priority over a coincident move tick.
          if (hit_valid) begin
            if (lethal) begin
              hp     <= '0;
              kill_q <= 1'b1;
              timer  <= TMR_W'(DEATH_FRAMES);
              state  <= DYING;
            end else begin
              hp    <= hp - HP_W'(bus.damage);
              timer <= TMR_W'(STUN_FRAMES);
              state <= STUN;
            end
          end else if (frame_edge) begin
            if (move_tick) begin
              div_cnt <= '0;
              if (moved) begin
                pos_x    <= cand_x;
                pos_y    <= y_moves ? cand_y : pos_y;
                dir      <= nxt_dir;
                step_cnt <= step_cnt + 2'd1;
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
        STUN: begin
          if (frame_edge) begin
            timer <= timer - TMR_W'(1);
            if (timer == TMR_W'(1)) begin
              div_cnt <= '0;
              state   <= CHASE;
            end
          end
        end
        DYING: begin
          if (frame_edge) begin
            timer <= timer - TMR_W'(1);
            if (timer == TMR_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sprite lookup: bounding-box test and ROM address for the current pixel.
  logic [POS_W:0] right_x, bottom_y;
  logic           in_box;
  logic [3:0]     frame_idx;

  always_comb begin
    right_x  = {1'b0, pos_x} + (POS_W + 1)'(WIDTH);
    bottom_y = {1'b0, pos_y} + (POS_W + 1)'(HEIGHT);
    in_box   = (state != IDLE)
            && (bus.PixelX >= pos_x) && ({1'b0, bus.PixelX} < right_x)
            && (bus.PixelY >= pos_y) && ({1'b0, bus.PixelY} < bottom_y);
    if (state == DYING) frame_idx = 4'd12;
    else frame_idx = ({2'b00, dir} * 4'd3)
                   + (step_cnt[0] ? (4'd1 + {3'b000, step_cnt[1]}) : 4'd0);
  end

  assign bus.is_obj        = in_box;
  assign bus.Obj_address   = in_box ? (ADDR_W'(bus.PixelX - pos_x)
                                     + ADDR_W'(bus.PixelY - pos_y) * ADDR_W'(WIDTH)
                                     + ADDR_W'(WIDTH * HEIGHT) * ADDR_W'(frame_idx))
                                    : '0;
  assign bus.Obj_X_Pos     = pos_x;
  assign bus.Obj_Y_Pos     = pos_y;
  assign bus.Obj_Direction = dir;
  assign bus.alive         = (state == CHASE) || (state == STUN);
  assign bus.kill          = kill_q;

endmodule

// File: doc/enemy_chaser.md
# enemy_chaser

Parametrised next-generation enemy sprite controller for the boxhead game. Each instance owns one enemy: it chases the player at a configurable speed, takes damage from bullet hits, stuns, plays a death frame, and respawns on request. It also produces the per-pixel hit flag and sprite-ROM address for the VGA compositor. The top level instantiates N copies with different spawn points and speeds.

## Interface
- SPAWN_X, 100: spawn centre X, in pixels.
- SPAWN_Y, 60: spawn centre Y, in pixels.
- WIDTH, 26: sprite width, in pixels.
- HEIGHT, 26: sprite height, in pixels.
- X_MAX, 319: rightmost screen column.
- Y_MAX, 239: bottom screen row.
- STEP, 1: pixels moved per move tick.
- SPEED_DIV, 4: frame edges per move tick (≥1).
- DIAGONAL, 0: 0 = X axis first, then Y; 1 = X and Y move in the same tick.
- MAX_HP, 3: hit points on spawn (≥1).
- STUN_FRAMES, 8: frame edges frozen after a non-lethal hit.
- DEATH_FRAMES, 30: frame edges the death sprite is shown.
- SPAWN_ON_RESET, 1: 1 = enter CHASE at reset; 0 = enter IDLE.
- ADDR_W, 14: sprite address width.
- Clk in 1: 50 MHz system clock.
- Reset in 1: reset Reset, synchronous, active-high; clock Clk.
- frame_clk in 1: ~60 Hz frame strobe, asynchronous level.
- spawn_req in 1: request to respawn; honoured only in IDLE.
- hit in 1: one-cycle bullet-hit pulse.
- damage in 2: HP removed per hit.
- Player_X, Player_Y in 9 each: player top-left position.
- PixelX, PixelY in 9 each: current draw pixel.
- is_obj out 1: current pixel lies inside the sprite and the enemy is visible.
- Obj_address out ADDR_W: sprite ROM address.
- Obj_X_Pos, Obj_Y_Pos out 9 each: enemy top-left position.
- Obj_Direction out 2: 0 down, 1 left, 2 up, 3 right.
- alive out 1: high in CHASE and STUN.
- kill out 1: one-cycle pulse on a lethal hit.

## Operation
- States: IDLE, CHASE, STUN, DYING.
- Reset:
  - Pos = (SPAWN_X−WIDTH/2, SPAWN_Y−HEIGHT/2); Direction = 0; hp = MAX_HP; step count = 0; kill = 0.
  - State = CHASE if SPAWN_ON_RESET, else IDLE.
- IDLE: invisible (is_obj = 0, address 0).
  - spawn_req → reload position and hp as at reset, Direction = 0, go to CHASE.
- CHASE: on each move tick, move toward the player.
  - X: if Pos_X < Player_X, move +min(STEP, Player_X−Pos_X) and set Direction = 3. If greater, move −min(STEP, Pos_X−Player_X) and set Direction = 1. Never overshoot.
  - Y (down/up, Direction 0/2) uses the same rule. With DIAGONAL = 0, Y moves only when Pos_X == Player_X. With DIAGONAL = 1, Y also moves in ticks where X moves, and Direction follows the X axis.
  - Clamp: Pos_X ∈ [0, X_MAX−WIDTH], Pos_Y ∈ [0, Y_MAX−HEIGHT]. A move that would exceed the bound stops at the bound.
  - No motion on either axis: no position change, Direction and step count hold.
  - Any motion: the 2-bit step count increments, wrapping from 3 to 0.
- Hit in CHASE: if hp ≤ damage, set hp = 0, pulse kill, go to DYING. Otherwise hp −= damage and go to STUN.
  - damage = 0 has no effect.
  - Hits in IDLE, STUN, and DYING are ignored.
- STUN: no movement. After STUN_FRAMES frame edges, return to CHASE.
- DYING: no movement. After DEATH_FRAMES frame edges, go to IDLE.
- Sprite frame index:
  - CHASE/STUN: Direction*3 when step count[0] = 0; otherwise Direction*3 + 1 + step count[1].
  - DYING: 12.
- Obj_address = (PixelX−Pos_X) + (PixelY−Pos_Y)·WIDTH + WIDTH·HEIGHT·frame, truncated to ADDR_W.
- is_obj = visible ∧ Pos_X ≤ PixelX < Pos_X+WIDTH ∧ Pos_Y ≤ PixelY < Pos_Y+HEIGHT. When is_obj = 0, address = 0.

## Timing
- Frame-edge path:
  - frame_clk is double-registered, then rising-edge detected, giving a one-Clk edge pulse 3 Clk cycles after frame_clk rises.
  - A divider counter (0..SPEED_DIV−1) produces the move tick on the edge pulse where the count wraps. The counter clears on reset and on entry to CHASE.
- Position, Direction, and step count register on the Clk edge after the tick, so they are visible 1 cycle after the tick.
- Stun and death counters decrement on edge pulses. Leaving the state occurs on the edge pulse that reaches 0.
- kill is asserted the cycle after the lethal hit, for exactly 1 cycle. The state changes to DYING in that same cycle.
- hit and move tick in the same cycle: the hit is processed and no move occurs.
- spawn_req and Reset together: Reset wins.
- is_obj and Obj_address are combinational from PixelX/Y and registered state; there is no pipeline latency.
- Reset mid-DYING or mid-STUN returns immediately to the reset state. No kill pulse is issued.

## Test plan
- Chase, X first: reset; Player = (200,87), Pos = (87,47), SPEED_DIV = 4, STEP = 1.
  - After 16 frame edges: Pos_X = 91, Direction = 3.
  - Once Pos_X reaches 200: Y increments, Direction = 0.
- No overshoot and clamp: STEP = 4, Pos_X = 198, Player_X = 200 → Pos_X = 200 after one tick.
  - Player_X = 310 → Pos_X stops at 293.
- Damage: MAX_HP = 3, damage = 1, two hits → STUN twice, no movement for 8 edges each.
  - Third hit → kill pulses 1 cycle, DYING, address frame 12.
  - After 30 edges → IDLE, is_obj = 0.
- Respawn: in IDLE, pulse spawn_req → Pos = (87,47), hp = 3, CHASE, alive = 1.
  - spawn_req in CHASE is ignored.
- Sprite address: Pos = (10,10), Direction = 3, step count = 3, Pixel = (12,13) → address = 2 + 78 + 676·11 = 7516.
  - Pixel = (36,10) → is_obj = 0.
- Simultaneous events: hit coincident with move tick → no move.
  - Reset asserted during DYING → CHASE at spawn point, kill stays 0.
